// File: rtl/frame_sync_cfg_scheduler.sv
// frame_sync_cfg_scheduler: queues SPI config writes and applies them to the live
// colour/misc registers and sprite chain only during vertical blanking.
module frame_sync_cfg_scheduler #(
    parameter int         DEPTH          = 4,
    parameter int         SPRITE_BITS    = 144,
    parameter logic [5:0] COLOR1_DEFAULT = 6'b110001,
    parameter logic [5:0] COLOR2_DEFAULT = 6'b010101,
    parameter logic [5:0] COLOR3_DEFAULT = 6'b001100,
    parameter logic [5:0] COLOR4_DEFAULT = 6'b101100,
    parameter logic [4:0] MISC_DEFAULT   = 5'b00110
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     vblank,
    input  logic                     next_frame,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [2:0]               wr_addr,
    input  logic [7:0]               wr_data,
    output logic [5:0]               color1,
    output logic [5:0]               color2,
    output logic [5:0]               color3,
    output logic [5:0]               color4,
    output logic [4:0]               misc,
    output logic                     sprite_shift,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SPRITE_BITS + 1);

    typedef enum logic [1:0] {IDLE, ROTATE, BARRIER} state_t;

    state_t        state, state_next;
    logic [10:0]   mem [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic [CW-1:0] cnt, cnt_next;
    logic          push, pop;
    logic [2:0]    head_addr;
    logic [7:0]    head_data;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign pending  = wptr - rptr;
    assign wr_ready = pending != (AW+1)'(DEPTH);
    assign push     = wr_valid && wr_ready;
    assign {head_addr, head_data} = mem[rptr[AW-1:0]];
    assign busy     = state != IDLE || pending != '0;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pop          = 1'b0;
        sprite_shift = 1'b0;
        if (state == IDLE) begin
            pop = vblank && pending != '0;
            if (pop && head_addr == 3'd6) begin
                state_next = ROTATE;
                cnt_next   = head_data == 8'd0 ? CW'(SPRITE_BITS) : CW'(head_data);
            end
            if (pop && head_addr == 3'd7) state_next = BARRIER;
        end else if (state == ROTATE) begin
            sprite_shift = vblank;
            cnt_next     = vblank ? cnt - CW'(1) : cnt;
            if (vblank && cnt == CW'(1)) state_next = IDLE;
        end else if (next_frame) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr   <= '0;
            rptr   <= '0;
            color1 <= COLOR1_DEFAULT;
            color2 <= COLOR2_DEFAULT;
            color3 <= COLOR3_DEFAULT;
            color4 <= COLOR4_DEFAULT;
            misc   <= MISC_DEFAULT;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= {wr_addr, wr_data};
                wptr              <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
                if (head_addr == 3'd0) color1 <= head_data[5:0];
                if (head_addr == 3'd1) color2 <= head_data[5:0];
                if (head_addr == 3'd2) color3 <= head_data[5:0];
                if (head_addr == 3'd3) color4 <= head_data[5:0];
                if (head_addr == 3'd4) misc   <= head_data[4:0];
            end
        end
    end
endmodule

// File: tb/tb_frame_sync_cfg_scheduler.sv
// tb_frame_sync_cfg_scheduler: directed vector table plus hand-written sequences
// for rotation bursts, frame barriers, FIFO full and reset abort.
module tb_frame_sync_cfg_scheduler;
    logic       clk = 1'b0;
    logic       reset_n, vblank, next_frame, wr_valid, wr_ready;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] color1, color2, color3, color4;
    logic [4:0] misc;
    logic       sprite_shift, busy;
    logic [2:0] pending;
    int         checks = 0;
    int         errors = 0;

    frame_sync_cfg_scheduler dut (
        .clk(clk), .reset_n(reset_n), .vblank(vblank), .next_frame(next_frame),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .color1(color1), .color2(color2), .color3(color3), .color4(color4),
        .misc(misc), .sprite_shift(sprite_shift), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vb;
        logic       v;
        logic [2:0] a;
        logic [7:0] d;
        logic [5:0] c1;
        logic [5:0] c2;
        logic [4:0] m;
        logic [2:0] p;
        logic       rdy;
        logic       sh;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rotate(input logic [7:0] d, input int pause_at, output int total, output int pshift);
        int paused;
        total  = 0;
        pshift = 0;
        paused = 0;
        vblank = 1'b1;
        push(3'd6, d);
        for (int i = 0; i < 400 && busy; i++) begin
            vblank = !(total == pause_at && paused < 20);
            if (!vblank) paused++;
            #1;
            if (sprite_shift) begin
                total++;
                if (!vblank) pshift++;
            end
            step();
        end
        vblank = 1'b1;
        chk("rot_done", busy, 0);
    endtask

    task automatic chk_defaults(input string tag);
        chk({tag, "_c1"}, color1, 6'h31);
        chk({tag, "_c2"}, color2, 6'h15);
        chk({tag, "_c3"}, color3, 6'h0C);
        chk({tag, "_c4"}, color4, 6'h2C);
        chk({tag, "_misc"}, misc, 5'h06);
        chk({tag, "_pend"}, pending, 0);
        chk({tag, "_rdy"}, wr_ready, 1);
        chk({tag, "_shift"}, sprite_shift, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        vec_t vecs[13];
        int   tot, ps;
        vecs[0]  = '{0, 1, 3'd0, 8'h3F, 6'h31, 6'h15, 5'h06, 3'd1, 1, 0};
        vecs[1]  = '{0, 0, 3'd0, 8'h00, 6'h31, 6'h15, 5'h06, 3'd1, 1, 0};
        vecs[2]  = '{1, 0, 3'd0, 8'h00, 6'h3F, 6'h15, 5'h06, 3'd0, 1, 0};
        vecs[3]  = '{1, 1, 3'd1, 8'h2A, 6'h3F, 6'h15, 5'h06, 3'd1, 1, 0};
        vecs[4]  = '{1, 1, 3'd4, 8'h1F, 6'h3F, 6'h2A, 5'h06, 3'd1, 1, 0};
        vecs[5]  = '{1, 1, 3'd5, 8'h0A, 6'h3F, 6'h2A, 5'h1F, 3'd1, 1, 0};
        vecs[6]  = '{1, 0, 3'd0, 8'h00, 6'h3F, 6'h2A, 5'h1F, 3'd0, 1, 0};
        vecs[7]  = '{1, 1, 3'd6, 8'h03, 6'h3F, 6'h2A, 5'h1F, 3'd1, 1, 0};
        vecs[8]  = '{1, 0, 3'd0, 8'h00, 6'h3F, 6'h2A, 5'h1F, 3'd0, 1, 1};
        vecs[9]  = '{1, 0, 3'd0, 8'h00, 6'h3F, 6'h2A, 5'h1F, 3'd0, 1, 1};
        vecs[10] = '{0, 0, 3'd0, 8'h00, 6'h3F, 6'h2A, 5'h1F, 3'd0, 1, 0};
        vecs[11] = '{1, 0, 3'd0, 8'h00, 6'h3F, 6'h2A, 5'h1F, 3'd0, 1, 1};
        vecs[12] = '{1, 0, 3'd0, 8'h00, 6'h3F, 6'h2A, 5'h1F, 3'd0, 1, 0};

        reset_n = 1'b0; vblank = 1'b0; next_frame = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        step();
        step();
        chk_defaults("reset");
        reset_n = 1'b1;
        step();
        chk_defaults("idle");

        for (int i = 0; i < 13; i++) begin
            vblank   = vecs[i].vb;
            wr_valid = vecs[i].v;
            wr_addr  = vecs[i].a;
            wr_data  = vecs[i].d;
            step();
            chk($sformatf("vec%0d_c1", i), color1, vecs[i].c1);
            chk($sformatf("vec%0d_c2", i), color2, vecs[i].c2);
            chk($sformatf("vec%0d_misc", i), misc, vecs[i].m);
            chk($sformatf("vec%0d_pend", i), pending, vecs[i].p);
            chk($sformatf("vec%0d_rdy", i), wr_ready, vecs[i].rdy);
            chk($sformatf("vec%0d_shift", i), sprite_shift, vecs[i].sh);
        end
        wr_valid = 1'b0;

        rotate(8'd5, -1, tot, ps);
        chk("rot5_count", tot, 5);
        rotate(8'd0, -1, tot, ps);
        chk("rot0_count", tot, 144);
        rotate(8'd0, 60, tot, ps);
        chk("rot_pause_total", tot, 144);
        chk("rot_pause_remaining", tot - 60, 84);
        chk("rot_pause_shift_low", ps, 0);

        vblank = 1'b1;
        push(3'd0, 8'h01);
        push(3'd7, 8'h00);
        push(3'd0, 8'h02);
        chk("bar_c1_first", color1, 6'h01);
        for (int i = 0; i < 5; i++) step();
        chk("bar_hold_c1", color1, 6'h01);
        chk("bar_hold_pend", pending, 1);
        chk("bar_busy", busy, 1);
        vblank = 1'b0;
        next_frame = 1'b1;
        step();
        next_frame = 1'b0;
        step();
        chk("bar_novb_c1", color1, 6'h01);
        chk("bar_novb_pend", pending, 1);
        vblank = 1'b1;
        step();
        chk("bar_release_c1", color1, 6'h02);
        chk("bar_release_pend", pending, 0);

        wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 8'h00;
        step();
        next_frame = 1'b1; wr_addr = 3'd0; wr_data = 8'h33;
        step();
        next_frame = 1'b0; wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("bar_same_cycle_c1", color1, 6'h02);
        chk("bar_same_cycle_pend", pending, 1);
        next_frame = 1'b1;
        step();
        next_frame = 1'b0;
        step();
        chk("bar_same_cycle_release", color1, 6'h33);

        vblank = 1'b0;
        for (int i = 1; i <= 4; i++) push(3'd2, 8'(i));
        chk("full_pend", pending, 4);
        chk("full_rdy", wr_ready, 0);
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'h07;
        step();
        chk("full_hold_pend", pending, 4);
        vblank = 1'b1;
        step();
        chk("full_pop_pend", pending, 3);
        chk("full_pop_rdy", wr_ready, 1);
        step();
        chk("full_pushpop_pend", pending, 3);
        wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("full_drain_pend", pending, 0);
        chk("full_drain_c3", color3, 6'h04);
        chk("full_drain_c4", color4, 6'h07);

        push(3'd6, 8'd0);
        push(3'd0, 8'h11);
        push(3'd1, 8'h22);
        push(3'd4, 8'h03);
        chk("rst_pre_shift", sprite_shift, 1);
        chk("rst_pre_pend", pending, 3);
        reset_n = 1'b0;
        step();
        chk_defaults("abort");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("abort_after_c1", color1, 6'h31);
        chk("abort_after_pend", pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
